wb_fifo_bank: RTL
=================

WB_FIFO_BANK -- requirements
Module: wb_fifo_bank

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 9, Wishbone word-address width.
REQ-002 SHALL have parameter DATAWIDTH, default 32, FIFO and bus data width.
REQ-003 SHALL have parameter NUM_CH, default 4, legal 1..4, number of FIFO channels.
REQ-004 SHALL have parameter DEPTH_LOG2, default 9, giving a per-channel depth of 2**DEPTH_LOG2 words.
REQ-005 SHALL have parameter DEF_REG_VALUE, default 32'hFAB_DEF_AC, read value for unmapped addresses.
REQ-006 SHALL have port WBs_CLK_i, input, 1, the single clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port WBs_RST_N_i, input, 1, reset; reset is asynchronous and active-low.
REQ-008 SHALL have ports WBs_ADR_i (input, ADDRWIDTH), WBs_CYC_i (input, 1), WBs_STB_i (input, 1) and WBs_WE_i (input, 1) as Wishbone slave controls.
REQ-009 SHALL have ports WBs_BYTE_STB_i (input, 4) as byte enables and WBs_DAT_i (input, DATAWIDTH) as write data.
REQ-010 SHALL have ports WBs_DAT_o (output, DATAWIDTH) as registered read data and WBs_ACK_o (output, 1) as acknowledge.
REQ-011 SHALL have port Interrupt_o, output, 1, level interrupt.

Function
REQ-012 SHALL decode the global map: 0x000 ID (read-only 32'hF1F07E57), 0x001 REV (read-only 0x0200), 0x002 IRQ_EN (read/write, bits [4c+3:4c] for channel c).
REQ-013 SHALL place channel c at base 0x040+0x10*c, with offsets +0 DATA, +1 STATUS, +2 CTRL, +3 IRQ_STAT.
REQ-014 SHALL read back DEF_REG_VALUE and ignore writes for any address of a channel index >= NUM_CH, and for any other unmapped address.
REQ-015 SHALL assert WBs_ACK_o for exactly one cycle, in the cycle after CYC&STB&~ACK, with no wait states, and SHALL register WBs_DAT_o on that same edge.
REQ-016 SHALL, on a DATA write, push WBs_DAT_i if the FIFO is not full; a write to a full FIFO SHALL drop the data and set sticky OVF.
REQ-017 SHALL, on a DATA read, return the head word (first-word-fall-through) and pop it on the ACK edge; a read of an empty FIFO SHALL return 0, leave state unchanged and set sticky UNF.
REQ-018 SHALL encode STATUS as: [DEPTH_LOG2:0] level (0..2**DEPTH_LOG2), [24] empty, [25] full, [26] level>=AF_THR, [27] level<=AE_THR.
REQ-019 SHALL encode CTRL as: [DEPTH_LOG2-1:0] AF_THR (reset 2**DEPTH_LOG2-4), [DEPTH_LOG2+15:16] AE_THR (reset 4), and [31] FLUSH, which is write-1 self-clearing, empties the FIFO in one cycle and reads as 0.
REQ-020 SHALL encode IRQ_STAT as sticky W1C bits: [0] OVF, [1] UNF, [2] AF rising edge, [3] AE rising edge; a set event SHALL win over a simultaneous W1C of the same bit.
REQ-021 SHALL apply byte enables to IRQ_EN, CTRL and IRQ_STAT; a DATA push SHALL require all four byte strobes, otherwise the write is ignored and OVF is not set.
REQ-022 SHALL, for a same-cycle push and pop on the Wishbone side, never coexist, because one access is in flight per channel; a FLUSH write SHALL clear level, pointers and AF/AE edge history without setting any IRQ bit.
REQ-023 SHALL wrap pointers modulo 2**DEPTH_LOG2, and SHALL keep the level counter DEPTH_LOG2+1 bits wide so that full is distinguishable from empty.
REQ-024 SHALL drive Interrupt_o as the registered OR over all channels of (IRQ_STAT & IRQ_EN nibble), with 1 cycle of latency from the flag update.

Reset
REQ-025 SHALL, on WBs_RST_N_i low, immediately and asynchronously clear WBs_ACK_o=0, WBs_DAT_o=0, Interrupt_o=0, IRQ_EN=0, all IRQ_STAT=0 and all FIFOs to empty, and set CTRL thresholds to their reset values.
REQ-026 SHALL, on reset mid-transaction, drop the transaction, and SHALL not issue an ACK in the first cycle after release.

Structure
REQ-027 SHALL hold register offsets, the global addresses, the ID/REV constants and the STATUS/IRQ_STAT bit positions in package wb_fifo_bank_pkg.
REQ-028 SHALL implement one sub-module, wb_fifo_chan (sync FIFO with storage, pointers, level, FWFT head, flush and AF/AE compare), generated NUM_CH times.

Verification
REQ-029 SHALL cover: push 0x11,0x22,0x33 to ch0, then read DATA x3 -> 0x11,0x22,0x33, and STATUS[24]=1 afterwards.
REQ-030 SHALL cover: push 513 words into a DEPTH_LOG2=9 channel -> STATUS level=512, full=1, IRQ_STAT[0]=1, and a drain returns the first 512 words.
REQ-031 SHALL cover: read DATA of an empty ch2 -> read data 0, IRQ_STAT[1]=1; with IRQ_EN[9]=1, Interrupt_o rises; W1C 0x2 -> Interrupt_o falls.
REQ-032 SHALL cover: AF_THR=8, push 8 words -> STATUS[26]=1 and IRQ_STAT[2]=1; write CTRL[31]=1 -> level=0 and IRQ_STAT unchanged.
REQ-033 SHALL cover: NUM_CH=2, access to 0x060 -> read DEF_REG_VALUE, and a write has no effect.
REQ-034 SHALL cover: assert WBs_RST_N_i low mid-read -> ACK=0 immediately, all FIFOs empty, CTRL reads AF_THR=508, AE_THR=4.

Source files
------------

// File: rtl/wb_fifo_bank_pkg.sv
// wb_fifo_bank_pkg
//   Shared constants for the Wishbone FIFO bank: global register addresses,
//   per-channel register offsets, ID/REV values, STATUS/CTRL/IRQ_STAT bit
//   positions, the decoded channel-access struct and a byte-enable merge helper.
package wb_fifo_bank_pkg;

    localparam int MAX_CH = 4;

    // Global map
    localparam int ADR_ID     = 'h000;
    localparam int ADR_REV    = 'h001;
    localparam int ADR_IRQ_EN = 'h002;
    localparam int CH_BASE    = 'h040;   // channel c at CH_BASE + CH_STRIDE*c
    localparam int CH_STRIDE  = 'h010;

    localparam logic [31:0] ID_VALUE  = 32'hF1F0_7E57;
    localparam logic [31:0] REV_VALUE = 32'h0000_0200;

    // Channel register offsets (low two bits of the in-channel offset)
    localparam logic [1:0] OFS_DATA     = 2'd0;
    localparam logic [1:0] OFS_STATUS   = 2'd1;
    localparam logic [1:0] OFS_CTRL     = 2'd2;
    localparam logic [1:0] OFS_IRQ_STAT = 2'd3;

    // STATUS bits
    localparam int ST_EMPTY = 24;
    localparam int ST_FULL  = 25;
    localparam int ST_AF    = 26;
    localparam int ST_AE    = 27;

    // CTRL fields
    localparam int CTRL_AE_LSB = 16;
    localparam int CTRL_FLUSH  = 31;

    // IRQ_STAT bits
    localparam int IRQ_OVF = 0;
    localparam int IRQ_UNF = 1;
    localparam int IRQ_AF  = 2;
    localparam int IRQ_AE  = 3;

    typedef struct packed {
        logic       hit;      // mapped register of an implemented channel
        logic [1:0] ch;
        logic [1:0] reg_sel;
    } ch_dec_t;

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (cur & ~m) | (wdat & m);
    endfunction

endpackage

// File: rtl/wb_fifo_bank_if.sv
// wb_fifo_bank_if
//   Wishbone slave bus bundle for wb_fifo_bank.
//   slave  : ADR/CYC/STB/WE/BYTE_STB/DAT_i in, DAT_o/ACK_o out
//   master : the mirror image, used by whatever drives the bus
interface wb_fifo_bank_if #(
    parameter int ADDRWIDTH = 9,
    parameter int DATAWIDTH = 32
);
    logic [ADDRWIDTH-1:0] WBs_ADR_i;
    logic                 WBs_CYC_i;
    logic                 WBs_STB_i;
    logic                 WBs_WE_i;
    logic [3:0]           WBs_BYTE_STB_i;
    logic [DATAWIDTH-1:0] WBs_DAT_i;
    logic [DATAWIDTH-1:0] WBs_DAT_o;
    logic                 WBs_ACK_o;

    modport slave (
        input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
        output WBs_DAT_o, WBs_ACK_o
    );

    modport master (
        output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_DAT_i,
        input  WBs_DAT_o, WBs_ACK_o
    );
endinterface

// File: rtl/wb_fifo_bank_chan.sv
// wb_fifo_chan
//   One synchronous FIFO channel: storage, wrapping pointers, level counter,
//   first-word-fall-through head, single-cycle flush and AF/AE compare with
//   rising-edge detect.
//   Ports: WBs_CLK_i/WBs_RST_N_i clock and async active-low reset;
//          push/wdata, pop, flush requests; af_thr/ae_thr thresholds;
//          head, level, empty, full, af, ae, af_rise, ae_rise status.
module wb_fifo_chan #(
    parameter int DATAWIDTH  = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  WBs_CLK_i,
    input  logic                  WBs_RST_N_i,
    input  logic                  push,
    input  logic [DATAWIDTH-1:0]  wdata,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DEPTH_LOG2-1:0] af_thr,
    input  logic [DEPTH_LOG2-1:0] ae_thr,
    output logic [DATAWIDTH-1:0]  head,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  af,
    output logic                  ae,
    output logic                  af_rise,
    output logic                  ae_rise
);
    localparam int DEPTH = 2**DEPTH_LOG2;

    logic [DATAWIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  af_q, ae_q, flush_d;
    logic                  do_push, do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign af      = (level >= {1'b0, af_thr});
    assign ae      = (level <= {1'b0, ae_thr});
    assign do_push = push & ~full  & ~flush;
    assign do_pop  = pop  & ~empty & ~flush;

    // Edges are masked for one cycle after reset or flush: the compare flags
    // jump to their empty-FIFO values then, which is not a threshold crossing.
    assign af_rise = af & ~af_q & ~flush_d;
    assign ae_rise = ae & ~ae_q & ~flush_d;

    always_ff @(posedge WBs_CLK_i)
        if (do_push) mem[wr_ptr] <= wdata;

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_N_i) begin
        if (!WBs_RST_N_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            af_q    <= 1'b0;
            ae_q    <= 1'b0;
            flush_d <= 1'b1;
        end else begin
            flush_d <= flush;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                af_q   <= 1'b0;
                ae_q   <= 1'b0;
            end else begin
                af_q <= af;
                ae_q <= ae;
                if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                level <= level + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
            end
        end
    end
endmodule

// File: rtl/wb_fifo_bank.sv
// wb_fifo_bank
//   Wishbone slave exposing NUM_CH FIFO channels plus ID/REV/IRQ_EN globals.
//   Zero-wait-state: ACK and registered read data one cycle after a request.
//   Ports: WBs_CLK_i clock, WBs_RST_N_i async active-low reset,
//          wb (slave modport) Wishbone bus, Interrupt_o registered level IRQ.
module wb_fifo_bank
    import wb_fifo_bank_pkg::*;
#(
    parameter int          ADDRWIDTH     = 9,
    parameter int          DATAWIDTH     = 32,
    parameter int          NUM_CH        = 4,
    parameter int          DEPTH_LOG2    = 9,
    parameter logic [31:0] DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
    input  logic                WBs_CLK_i,
    input  logic                WBs_RST_N_i,
    wb_fifo_bank_if.slave       wb,
    output logic                Interrupt_o
);
    localparam logic [31:0] THR_MASK    = 32'((2**DEPTH_LOG2) - 1);
    localparam logic [31:0] CTRL_MASK   = THR_MASK | (THR_MASK << CTRL_AE_LSB);
    localparam logic [31:0] CTRL_RST    = 32'((2**DEPTH_LOG2) - 4) | (32'd4 << CTRL_AE_LSB);
    localparam logic [31:0] IRQ_EN_MASK = 32'((1 << (4*NUM_CH)) - 1);

    logic                 req, rd, wr, rst_done, irq_any;
    logic [31:0]          wdat, irq_en;
    logic [ADDRWIDTH-1:0] adr;
    logic [3:0]           be;
    ch_dec_t              dec;
    logic [DATAWIDTH-1:0] rdata;

    logic [MAX_CH-1:0][DATAWIDTH-1:0] head_v;
    logic [MAX_CH-1:0][31:0]          status_v, ctrl_v;
    logic [MAX_CH-1:0][3:0]           irq_v;
    logic [MAX_CH-1:0]                empty_v;

    assign adr  = wb.WBs_ADR_i;
    assign be   = wb.WBs_BYTE_STB_i;
    assign wdat = wb.WBs_DAT_i[31:0];

    // rst_done holds off the first edge after reset release so a request
    // still on the bus is not acknowledged immediately.
    assign req = wb.WBs_CYC_i & wb.WBs_STB_i & ~wb.WBs_ACK_o & rst_done;
    assign rd  = req & ~wb.WBs_WE_i;
    assign wr  = req &  wb.WBs_WE_i;

    // Channel window 0x040..0x07F: bits [5:4] channel, [3:0] offset.
    assign dec.ch      = adr[5:4];
    assign dec.reg_sel = adr[1:0];
    assign dec.hit     = (adr[ADDRWIDTH-1:6] == (ADDRWIDTH-6)'(1)) &&
                         (adr[3:2] == 2'b00) && (int'(adr[5:4]) < NUM_CH);

    for (genvar c = 0; c < MAX_CH; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            logic                  acc, push, pop, flush, ctrl_wr, stat_wr;
            logic                  ovf_set, unf_set;
            logic [DATAWIDTH-1:0]  head;
            logic [DEPTH_LOG2:0]   level;
            logic                  empty, full, af, ae, af_rise, ae_rise;
            logic [31:0]           ctrl_q;
            logic [3:0]            irq_stat, w1c;

            assign acc     = dec.hit && (dec.ch == 2'(c));
            assign push    = acc & wr & (dec.reg_sel == OFS_DATA) & (be == 4'hF) & ~full;
            assign ovf_set = acc & wr & (dec.reg_sel == OFS_DATA) & (be == 4'hF) &  full;
            assign pop     = acc & rd & (dec.reg_sel == OFS_DATA) & ~empty;
            assign unf_set = acc & rd & (dec.reg_sel == OFS_DATA) &  empty;
            assign ctrl_wr = acc & wr & (dec.reg_sel == OFS_CTRL);
            assign stat_wr = acc & wr & (dec.reg_sel == OFS_IRQ_STAT);
            assign flush   = ctrl_wr & be[3] & wdat[CTRL_FLUSH];
            assign w1c     = stat_wr ? (wdat[3:0] & {4{be[0]}}) : 4'h0;

            wb_fifo_chan #(.DATAWIDTH(DATAWIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_chan (
                .WBs_CLK_i   (WBs_CLK_i),
                .WBs_RST_N_i (WBs_RST_N_i),
                .push        (push),
                .wdata       (wb.WBs_DAT_i),
                .pop         (pop),
                .flush       (flush),
                .af_thr      (ctrl_q[DEPTH_LOG2-1:0]),
                .ae_thr      (ctrl_q[CTRL_AE_LSB +: DEPTH_LOG2]),
                .head        (head),
                .level       (level),
                .empty       (empty),
                .full        (full),
                .af          (af),
                .ae          (ae),
                .af_rise     (af_rise),
                .ae_rise     (ae_rise)
            );

            // FLUSH is never stored: it is masked out by CTRL_MASK.
            always_ff @(posedge WBs_CLK_i or negedge WBs_RST_N_i) begin
                if (!WBs_RST_N_i) begin
                    ctrl_q   <= CTRL_RST;
                    irq_stat <= '0;
                end else begin
                    if (ctrl_wr) ctrl_q <= be_merge(ctrl_q, wdat, be) & CTRL_MASK;
                    // set terms applied after the clear so a new event wins
                    irq_stat <= (irq_stat & ~w1c) | {ae_rise, af_rise, unf_set, ovf_set};
                end
            end

            assign head_v[c]   = head;
            assign empty_v[c]  = empty;
            assign ctrl_v[c]   = ctrl_q;
            assign irq_v[c]    = irq_stat;
            assign status_v[c] = 32'(level) | (32'(empty) << ST_EMPTY) | (32'(full) << ST_FULL)
                               | (32'(af) << ST_AF) | (32'(ae) << ST_AE);
        end else begin : g_off
            assign head_v[c]   = '0;
            assign empty_v[c]  = 1'b1;
            assign ctrl_v[c]   = '0;
            assign irq_v[c]    = '0;
            assign status_v[c] = '0;
        end
    end

    always_comb begin
        rdata = DATAWIDTH'(DEF_REG_VALUE);
        if (dec.hit) begin
            case (dec.reg_sel)
                OFS_DATA:   rdata = empty_v[dec.ch] ? '0 : head_v[dec.ch];
                OFS_STATUS: rdata = DATAWIDTH'(status_v[dec.ch]);
                OFS_CTRL:   rdata = DATAWIDTH'(ctrl_v[dec.ch]);
                default:    rdata = DATAWIDTH'(irq_v[dec.ch]);
            endcase
        end else if (adr == ADDRWIDTH'(ADR_ID)) begin
            rdata = DATAWIDTH'(ID_VALUE);
        end else if (adr == ADDRWIDTH'(ADR_REV)) begin
            rdata = DATAWIDTH'(REV_VALUE);
        end else if (adr == ADDRWIDTH'(ADR_IRQ_EN)) begin
            rdata = DATAWIDTH'(irq_en);
        end
    end

    always_comb begin
        irq_any = 1'b0;
        for (int c = 0; c < MAX_CH; c++)
            irq_any = irq_any | (|(irq_v[c] & irq_en[4*c +: 4]));
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_N_i) begin
        if (!WBs_RST_N_i) begin
            wb.WBs_ACK_o <= 1'b0;
            wb.WBs_DAT_o <= '0;
            rst_done     <= 1'b0;
            irq_en       <= '0;
            Interrupt_o  <= 1'b0;
        end else begin
            rst_done     <= 1'b1;
            wb.WBs_ACK_o <= req;
            Interrupt_o  <= irq_any;
            if (rd) wb.WBs_DAT_o <= rdata;
            if (wr && adr == ADDRWIDTH'(ADR_IRQ_EN))
                irq_en <= be_merge(irq_en, wdat, be) & IRQ_EN_MASK;
        end
    end
endmodule
